// File: rtl/ctrl_pkg.sv
// Shared definitions for the CR16-subset sequencer: ALU operation codes, instruction
// field encodings, sequencer states and status flag positions.
package ctrl_pkg;

    // ALU operation codes driven on OpCode
    localparam logic [4:0] ALU_NOP = 5'b00000;
    localparam logic [4:0] ALU_AND = 5'b00001;
    localparam logic [4:0] ALU_OR  = 5'b00010;
    localparam logic [4:0] ALU_XOR = 5'b00011;
    localparam logic [4:0] ALU_LSH = 5'b00100;
    localparam logic [4:0] ALU_ADD = 5'b00101;
    localparam logic [4:0] ALU_SUB = 5'b01001;
    localparam logic [4:0] ALU_CMP = 5'b01011;
    localparam logic [4:0] ALU_MOV = 5'b01101;

    // Primary opcode field IR[15:12]
    localparam logic [3:0] OP_REG   = 4'b0000;
    localparam logic [3:0] OP_ANDI  = 4'b0001;
    localparam logic [3:0] OP_ORI   = 4'b0010;
    localparam logic [3:0] OP_XORI  = 4'b0011;
    localparam logic [3:0] OP_ADDI  = 4'b0101;
    localparam logic [3:0] OP_SHIFT = 4'b1000;
    localparam logic [3:0] OP_SUBI  = 4'b1001;
    localparam logic [3:0] OP_CMPI  = 4'b1011;
    localparam logic [3:0] OP_MOVI  = 4'b1101;
    localparam logic [3:0] OP_LUI   = 4'b1111;

    // Extension field IR[7:4] for register and shift forms
    localparam logic [3:0] EXT_AND = 4'b0001;
    localparam logic [3:0] EXT_OR  = 4'b0010;
    localparam logic [3:0] EXT_XOR = 4'b0011;
    localparam logic [3:0] EXT_LSH = 4'b0100;
    localparam logic [3:0] EXT_ADD = 4'b0101;
    localparam logic [3:0] EXT_SUB = 4'b1001;
    localparam logic [3:0] EXT_CMP = 4'b1011;
    localparam logic [3:0] EXT_MOV = 4'b1101;

    localparam logic [15:0] HALT_WORD = 16'h0000;

    localparam int FLAG_W = 5;
    localparam int FLAG_C = 0;
    localparam int FLAG_L = 1;
    localparam int FLAG_F = 2;
    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_HALTED
    } state_t;

    function automatic logic [15:0] sext8(input logic [7:0] v);
        return {{8{v[7]}}, v};
    endfunction

    function automatic logic [15:0] zext8(input logic [7:0] v);
        return {8'h00, v};
    endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational decode of one 16-bit instruction word into datapath controls.
// The all-zero word is HALT and is decoded as a legal no-write instruction.
module instr_decoder
    import ctrl_pkg::*;
(
    input  logic [15:0] ir,
    output logic [3:0]  rdest,
    output logic [3:0]  rsrc,
    output logic [15:0] imm,
    output logic        imm_s,
    output logic [4:0]  opcode,
    output logic        writes_reg,
    output logic        sets_flags,
    output logic        illegal
);

    logic [3:0] op;
    logic [3:0] ext;
    logic [7:0] imm8;

    assign op   = ir[15:12];
    assign ext  = ir[7:4];
    assign imm8 = ir[7:0];

    always_comb begin
        rdest      = ir[11:8];
        rsrc       = ir[3:0];
        imm        = 16'h0000;
        imm_s      = 1'b0;
        opcode     = ALU_NOP;
        writes_reg = 1'b0;
        sets_flags = 1'b0;
        illegal    = 1'b0;

        case (op)
            OP_REG: begin
                case (ext)
                    EXT_AND: begin opcode = ALU_AND; writes_reg = 1'b1; end
                    EXT_OR:  begin opcode = ALU_OR;  writes_reg = 1'b1; end
                    EXT_XOR: begin opcode = ALU_XOR; writes_reg = 1'b1; end
                    EXT_MOV: begin opcode = ALU_MOV; writes_reg = 1'b1; end
                    EXT_ADD: begin opcode = ALU_ADD; writes_reg = 1'b1; sets_flags = 1'b1; end
                    EXT_SUB: begin opcode = ALU_SUB; writes_reg = 1'b1; sets_flags = 1'b1; end
                    EXT_CMP: begin opcode = ALU_CMP; sets_flags = 1'b1; end
                    // HALT shares this space but is a legal encoding
                    default: illegal = (ir != HALT_WORD);
                endcase
            end
            OP_ANDI: begin opcode = ALU_AND; imm = zext8(imm8); imm_s = 1'b1; writes_reg = 1'b1; end
            OP_ORI:  begin opcode = ALU_OR;  imm = zext8(imm8); imm_s = 1'b1; writes_reg = 1'b1; end
            OP_XORI: begin opcode = ALU_XOR; imm = zext8(imm8); imm_s = 1'b1; writes_reg = 1'b1; end
            OP_MOVI: begin opcode = ALU_MOV; imm = zext8(imm8); imm_s = 1'b1; writes_reg = 1'b1; end
            OP_ADDI: begin
                opcode = ALU_ADD; imm = sext8(imm8); imm_s = 1'b1;
                writes_reg = 1'b1; sets_flags = 1'b1;
            end
            OP_SUBI: begin
                opcode = ALU_SUB; imm = sext8(imm8); imm_s = 1'b1;
                writes_reg = 1'b1; sets_flags = 1'b1;
            end
            OP_CMPI: begin
                opcode = ALU_CMP; imm = sext8(imm8); imm_s = 1'b1; sets_flags = 1'b1;
            end
            OP_LUI: begin
                opcode = ALU_MOV; imm = {imm8, 8'h00}; imm_s = 1'b1; writes_reg = 1'b1;
            end
            OP_SHIFT: begin
                if (ext == EXT_LSH) begin
                    opcode = ALU_LSH; writes_reg = 1'b1;
                end else if (ext[3:1] == 3'b000) begin
                    // LSHI: 5-bit signed amount, negative shifts right
                    opcode = ALU_LSH; imm = {{11{ir[4]}}, ir[4:0]};
                    imm_s = 1'b1; writes_reg = 1'b1;
                end else begin
                    illegal = 1'b1;
                end
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Fetch/decode/execute sequencer: one instruction in flight, 3 cycles per instruction
// with zero-wait memory. Holds PC, IR and the latched status flags.
module alu_seq_ctrl
    import ctrl_pkg::*;
#(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] START_PC = '0
) (
    input  logic            Clk,
    input  logic            Rst,
    input  logic            start,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_valid,
    input  logic [15:0]     imem_data,
    input  logic [4:0]      alu_flags,
    output logic [3:0]      RdestRegLoc,
    output logic [3:0]      RsrcRegLoc,
    output logic [15:0]     Imm,
    output logic            Imm_s,
    output logic [4:0]      OpCode,
    output logic            En,
    output logic [4:0]      flags_q,
    output logic            busy,
    output logic            halted,
    output logic            illegal
);

    localparam logic [PC_W-1:0] PC_ONE = 1;

    state_t            state, state_nx;
    logic [PC_W-1:0]   pc, pc_nx;
    logic [15:0]       ir, ir_nx;
    logic [FLAG_W-1:0] flags_nx;

    logic [3:0]  d_rdest, d_rsrc;
    logic [15:0] d_imm;
    logic        d_imm_s;
    logic [4:0]  d_opcode;
    logic        d_writes, d_sets_flags, d_illegal;
    logic        dec_on, in_exec;

    instr_decoder u_dec (
        .ir         (ir),
        .rdest      (d_rdest),
        .rsrc       (d_rsrc),
        .imm        (d_imm),
        .imm_s      (d_imm_s),
        .opcode     (d_opcode),
        .writes_reg (d_writes),
        .sets_flags (d_sets_flags),
        .illegal    (d_illegal)
    );

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state   <= ST_IDLE;
            pc      <= START_PC;
            ir      <= 16'h0000;
            flags_q <= '0;
        end else begin
            state   <= state_nx;
            pc      <= pc_nx;
            ir      <= ir_nx;
            flags_q <= flags_nx;
        end
    end

    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        ir_nx    = ir;
        flags_nx = flags_q;
        case (state)
            ST_IDLE, ST_HALTED: begin
                if (start) begin
                    state_nx = ST_FETCH;
                    pc_nx    = START_PC;
                end
            end
            ST_FETCH: begin
                if (imem_valid) begin
                    ir_nx    = imem_data;
                    state_nx = ST_DECODE;
                end
            end
            ST_DECODE: state_nx = ST_EXEC;
            ST_EXEC: begin
                if (d_sets_flags) flags_nx = alu_flags;
                if (ir == HALT_WORD) begin
                    state_nx = ST_HALTED;
                end else begin
                    pc_nx    = pc + PC_ONE;
                    state_nx = ST_FETCH;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Decode fields are only meaningful once IR holds the fetched word
    assign dec_on  = (state == ST_DECODE) || (state == ST_EXEC);
    assign in_exec = (state == ST_EXEC);

    assign imem_req    = (state == ST_FETCH);
    assign imem_addr   = imem_req ? pc : '0;
    assign RdestRegLoc = dec_on ? d_rdest  : 4'h0;
    assign RsrcRegLoc  = dec_on ? d_rsrc   : 4'h0;
    assign Imm         = dec_on ? d_imm    : 16'h0000;
    assign Imm_s       = dec_on ? d_imm_s  : 1'b0;
    assign OpCode      = dec_on ? d_opcode : ALU_NOP;

    // A reset arriving during EXEC must suppress the write in that same cycle
    assign En      = Rst && in_exec && d_writes;
    assign illegal = Rst && in_exec && d_illegal;

    assign busy   = (state == ST_FETCH) || dec_on;
    assign halted = (state == ST_HALTED);

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: table of instructions with hand-derived decode results,
// plus sequences for wait states, PC wrap, HALT/restart and mid-instruction reset.
module tb_alu_seq_ctrl;
    import ctrl_pkg::*;

    logic        Clk, Rst, start;
    logic        imem_req, imem_valid;
    logic [7:0]  imem_addr;
    logic [15:0] imem_data;
    logic [4:0]  alu_flags;
    logic [3:0]  RdestRegLoc, RsrcRegLoc;
    logic [15:0] Imm;
    logic        Imm_s;
    logic [4:0]  OpCode;
    logic        En, busy, halted, illegal;
    logic [4:0]  flags_q;

    alu_seq_ctrl #(.PC_W(8), .START_PC(8'h00)) dut (
        .Clk(Clk), .Rst(Rst), .start(start),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_data(imem_data),
        .alu_flags(alu_flags),
        .RdestRegLoc(RdestRegLoc), .RsrcRegLoc(RsrcRegLoc),
        .Imm(Imm), .Imm_s(Imm_s), .OpCode(OpCode), .En(En),
        .flags_q(flags_q), .busy(busy), .halted(halted), .illegal(illegal)
    );

    typedef struct {
        logic [15:0] instr;
        logic [4:0]  flags;
        logic [3:0]  rd;
        logic [3:0]  rs;
        logic [15:0] imm;
        logic        imm_s;
        logic [4:0]  opc;
        logic        en;
        logic        ill;
        logic        sets;
    } vec_t;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_q[$];
    logic [7:0]  exp_pc;
    logic [4:0]  exp_flags;
    vec_t        tbl[16];
    vec_t        r_add, r_halt;

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input logic [15:0] instr, input logic [4:0] flags,
                                input logic [3:0] rd, input logic [3:0] rs,
                                input logic [15:0] imm, input logic imm_s,
                                input logic [4:0] opc, input logic en,
                                input logic ill, input logic sets);
        vec_t v;
        v.instr = instr; v.flags = flags; v.rd = rd; v.rs = rs; v.imm = imm;
        v.imm_s = imm_s; v.opc = opc; v.en = en; v.ill = ill; v.sets = sets;
        return v;
    endfunction

    function automatic logic [31:0] pack_exp(input vec_t v);
        return {v.en, v.ill, v.opc, v.imm_s, v.imm, v.rd, v.rs};
    endfunction

    function automatic logic [31:0] dut_out();
        return {En, illegal, OpCode, Imm_s, Imm, RdestRegLoc, RsrcRegLoc};
    endfunction

    function automatic logic [63:0] all_out();
        return {16'h0, imem_req, imem_addr, dut_out(), flags_q, busy, halted};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
    endtask

    // Ends at the negedge where the DUT sits in DECODE with the word latched
    task automatic do_fetch(input logic [15:0] instr, input int waitc, input bit poke);
        int n = 0;
        while (imem_req !== 1'b1 && n < 50) begin
            @(negedge Clk);
            n++;
        end
        check("fetch_req", imem_req, 1);
        check("fetch_addr", imem_addr, exp_pc);
        for (int i = 0; i < waitc; i++) begin
            start = poke && (i == 0);
            @(negedge Clk);
            start = 1'b0;
            check("wait_req", imem_req, 1);
            check("wait_addr", imem_addr, exp_pc);
            check("wait_en", En, 0);
        end
        imem_valid = 1'b1;
        imem_data  = instr;
        @(negedge Clk);
        imem_valid = 1'b0;
        imem_data  = 16'($urandom);
    endtask

    task automatic run_instr(input vec_t r, input int waitc, input bit poke);
        logic [31:0] exp;
        alu_flags = r.flags;
        do_fetch(r.instr, waitc, poke);
        exp_q.push_back(pack_exp(r));
        check($sformatf("decode_out %h", r.instr), dut_out(), exp_q[0] & 32'h3FFF_FFFF);
        check("decode_busy", busy, 1);
        @(negedge Clk);
        exp = exp_q.pop_front();
        check($sformatf("exec_out %h", r.instr), dut_out(), exp);
        if (r.sets) exp_flags = r.flags;
        if (r.instr != 16'h0000) exp_pc = exp_pc + 8'd1;
        @(negedge Clk);
        check($sformatf("flags_q %h", r.instr), flags_q, exp_flags);
        check("halted", halted, (r.instr == 16'h0000));
    endtask

    initial begin
        tbl[0]  = mk(16'h5105, 5'b00011, 4'h1, 4'h5, 16'h0005, 1, ALU_ADD, 1, 0, 1);
        tbl[1]  = mk(16'h92FF, 5'b01000, 4'h2, 4'hF, 16'hFFFF, 1, ALU_SUB, 1, 0, 1);
        tbl[2]  = mk(16'h22FF, 5'b11111, 4'h2, 4'hF, 16'h00FF, 1, ALU_OR,  1, 0, 0);
        tbl[3]  = mk(16'hF3AB, 5'b00000, 4'h3, 4'hB, 16'hAB00, 1, ALU_MOV, 1, 0, 0);
        tbl[4]  = mk(16'h01B2, 5'b10101, 4'h1, 4'h2, 16'h0000, 0, ALU_CMP, 0, 0, 1);
        tbl[5]  = mk(16'h04D2, 5'b01010, 4'h4, 4'h2, 16'h0000, 0, ALU_MOV, 1, 0, 0);
        tbl[6]  = mk(16'h0352, 5'b00110, 4'h3, 4'h2, 16'h0000, 0, ALU_ADD, 1, 0, 1);
        tbl[7]  = mk(16'h1780, 5'b11000, 4'h7, 4'h0, 16'h0080, 1, ALU_AND, 1, 0, 0);
        tbl[8]  = mk(16'hB6F0, 5'b11001, 4'h6, 4'h0, 16'hFFF0, 1, ALU_CMP, 0, 0, 1);
        tbl[9]  = mk(16'h8141, 5'b00001, 4'h1, 4'h1, 16'h0000, 0, ALU_LSH, 1, 0, 0);
        tbl[10] = mk(16'h851F, 5'b00010, 4'h5, 4'hF, 16'hFFFF, 1, ALU_LSH, 1, 0, 0);
        tbl[11] = mk(16'h8203, 5'b00100, 4'h2, 4'h3, 16'h0003, 1, ALU_LSH, 1, 0, 0);
        tbl[12] = mk(16'h0700, 5'b01110, 4'h7, 4'h0, 16'h0000, 0, ALU_NOP, 0, 1, 0);
        tbl[13] = mk(16'h4123, 5'b10001, 4'h1, 4'h3, 16'h0000, 0, ALU_NOP, 0, 1, 0);
        tbl[14] = mk(16'hD90F, 5'b10010, 4'h9, 4'hF, 16'h000F, 1, ALU_MOV, 1, 0, 0);
        tbl[15] = mk(16'h3A81, 5'b00111, 4'hA, 4'h1, 16'h0081, 1, ALU_XOR, 1, 0, 0);
        r_add   = tbl[6];
        r_halt  = mk(16'h0000, 5'b11111, 4'h0, 4'h0, 16'h0000, 0, ALU_NOP, 0, 0, 0);

        Rst = 1'b0; start = 1'b0; imem_valid = 1'b0; imem_data = 16'h0; alu_flags = 5'h0;
        exp_pc = 8'h00; exp_flags = 5'h00;
        repeat (3) @(negedge Clk);
        check("reset_outputs", all_out(), 64'h0);
        Rst = 1'b1;
        @(negedge Clk);
        check("idle_outputs", all_out(), 64'h0);
        pulse_start();

        for (int i = 0; i < 16; i++)
            run_instr(tbl[i], (i == 5) ? 4 : $urandom_range(0, 2), 1'b0);

        // Run up to PC=FF, then one more must wrap the fetch address to 00
        while (exp_pc != 8'hFF) begin
            r_add.flags = 5'($urandom_range(0, 31));
            run_instr(r_add, 0, 1'b0);
        end
        run_instr(r_add, 0, 1'b0);
        check("wrap_addr", imem_addr, 8'h00);
        run_instr(tbl[0], 0, 1'b0);

        run_instr(r_halt, 1, 1'b0);
        check("halt_busy", busy, 0);
        check("halt_req", imem_req, 0);
        check("halt_decode_zero", dut_out(), 32'h0);
        repeat (2) @(negedge Clk);
        check("halt_sticky", halted, 1);
        pulse_start();
        exp_pc = 8'h00;
        check("restart_addr", imem_addr, 8'h00);
        check("restart_flags", flags_q, exp_flags);
        run_instr(tbl[1], 0, 1'b0);
        run_instr(tbl[2], 2, 1'b1);

        // Reset while ADD is in DECODE: abandoned, no write, back to IDLE
        do_fetch(16'h0352, 0, 1'b0);
        check("rst_dec_en", En, 0);
        Rst = 1'b0;
        @(negedge Clk);
        check("rst_dec_idle", all_out(), 64'h0);
        Rst = 1'b1;
        exp_pc = 8'h00; exp_flags = 5'h00;
        pulse_start();

        // Reset while ADD is in EXEC: write enable must drop immediately
        do_fetch(16'h0352, 0, 1'b0);
        @(negedge Clk);
        check("exec_en_pre_rst", En, 1);
        Rst = 1'b0;
        #1;
        check("rst_exec_en", En, 0);
        @(negedge Clk);
        check("rst_exec_idle", all_out(), 64'h0);
        Rst = 1'b1;
        @(negedge Clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
